key_repeat_ctrl: RTL and testbench
==================================

# key_repeat_ctrl

Converts the held-key levels from the PS/2 keyboard decoder (left/right/down/up/space) into one-cycle game commands with auto-repeat. It sits between the keyboard decoder and the game controller and drives the controller's 3-bit keyboard command and reset inputs. Holding a movement key gives one immediate move, then a pause, then moves at a steady rate. Holding rotate gives exactly one rotation per press.

## Interface
- INIT_DELAY, 25_000_000: cycles from a press event to the first repeat (≥2; 250 ms at 100 MHz).
- REPEAT_PERIOD, 5_000_000: cycles between subsequent repeats (≥2; 50 ms at 100 MHz).
- clk  in  1  system clock, same clock as the game controller.
- rst  in  1  reset; one clock, synchronous, active-high.
- left  in  1  level, key held.
- right  in  1  level, key held.
- down  in  1  level, key held.
- up  in  1  level, key held (rotate).
- space  in  1  level, key held (restart).
- key_cmd  out  3  command code, valid for one cycle per event; 3'b000 otherwise.
- game_rst  out  1  one-cycle restart pulse to the game controller.

## Operation
- Input stage: all five key inputs are registered once (`*_q`). All logic below uses the registered values.
- Priority encode of the registered keys, highest first:
  - down → 3'b100
  - left → 3'b101
  - right → 3'b110
  - up → 3'b111
  - none → 3'b000
- FSM states: IDLE, DELAY, REPEAT, HOLD. Registers: `active` (3 bits) and `cnt` (width $clog2(max(INIT_DELAY, REPEAT_PERIOD))).
- Press event: the encoded value is non-zero and differs from `active`. On a press event:
  - emit the code on key_cmd;
  - set `active` to the code and clear `cnt`;
  - go to HOLD if the code is 3'b111, otherwise go to DELAY.
  - A press event is taken from any state.
- Release: the encoded value is 3'b000 while in DELAY, REPEAT or HOLD.
  - Go to IDLE, set `active` to 0, clear `cnt`.
  - No command is emitted.
- DELAY: `cnt` increments each cycle. When `cnt` == INIT_DELAY-1, emit `active`, clear `cnt`, go to REPEAT.
- REPEAT: when `cnt` == REPEAT_PERIOD-1, emit `active` and clear `cnt`. Stay in REPEAT.
- HOLD: no repeats. Leave only on a release or a press event.
- Key changes while held:
  - A higher-priority key pressed over a held key is a press event for the new key (timers restart).
  - Releasing the higher key while the lower one is still held is a press event for the lower key.
- Space: game_rst = space_q & ~space_qq, a one-cycle pulse on the rising edge only.
  - Holding space does not hold reset.
  - Space is independent of the direction FSM; a direction event and game_rst may fire in the same cycle.
- key_cmd is registered, so at most one code is emitted per cycle.

## Timing
- Reset values: key_cmd = 0, game_rst = 0, state = IDLE, `active` = 0, `cnt` = 0, all input registers = 0.
- Press latency: a key high before edge N appears on key_cmd for the cycle after edge N+1 (2 cycles).
- Repeat timing:
  - First repeat: exactly INIT_DELAY cycles after the press-event cycle.
  - Later repeats: every REPEAT_PERIOD cycles.
- Release latency: a key low before edge N cancels any repeat that would be emitted at or after edge N+1.
- rst asserted in any state: at the next edge all registers go to their reset values, dropping any pending repeat.
- A key held through reset release produces a press event 2 cycles after rst drops. The same applies to space, which yields a game_rst pulse.
- `cnt` never exceeds max(INIT_DELAY, REPEAT_PERIOD)-1. No wrap-around occurs.

## Structure
- Shared package tetris_pkg holds:
  - KEY_NONE / KEY_DOWN / KEY_LEFT / KEY_RIGHT / KEY_ROT code constants, which the game controller also uses;
  - the key_repeat_ctrl state enum.
- One combinational sub-module, key_prio_enc (four levels in, 3-bit code out), reused by any future input source.

## Test plan
All scenarios use INIT_DELAY=8 and REPEAT_PERIOD=4.
- Tap left for 3 cycles → exactly one key_cmd=3'b101 pulse, 2 cycles after the rise; then 3'b000.
- Hold right for 30 cycles → pulses at t0, t0+8, t0+12, t0+16, t0+20, t0+24, t0+28 (at most one per cycle); none after release latency.
- Hold up for 30 cycles → a single 3'b111 pulse. Release and re-press → a second single pulse.
- Hold left, then press down at cycle 10 → 3'b100 immediately, repeats re-timed from the down event. Release down with left still held → a fresh 3'b101 press event.
- Hold space for 20 cycles → game_rst high for exactly 1 cycle, 2 cycles after the rise. Space pressed during a right repeat → both outputs fire as scheduled.
- Assert rst at cnt=5 during DELAY with down held → key_cmd=0 during reset. After release, 3'b100 appears 2 cycles later and the first repeat is 8 cycles after that.

Source files
------------

// File: rtl/tetris_pkg.sv
// rtl/tetris_pkg.sv - key command codes and key_repeat_ctrl state encoding
package tetris_pkg;

   localparam logic [2:0] KEY_NONE  = 3'b000;
   localparam logic [2:0] KEY_DOWN  = 3'b100;
   localparam logic [2:0] KEY_LEFT  = 3'b101;
   localparam logic [2:0] KEY_RIGHT = 3'b110;
   localparam logic [2:0] KEY_ROT   = 3'b111;

   typedef enum logic [1:0] {
      KR_IDLE   = 2'd0,
      KR_DELAY  = 2'd1,
      KR_REPEAT = 2'd2,
      KR_HOLD   = 2'd3
   } kr_state_e;

endpackage

// File: rtl/key_prio_enc.sv
// rtl/key_prio_enc.sv - priority encoder from held key levels to a command code
module key_prio_enc
   import tetris_pkg::*;
(
   input  logic       down_i,
   input  logic       left_i,
   input  logic       right_i,
   input  logic       up_i,
   output logic [2:0] code_o
);

   always_comb begin
      code_o = KEY_NONE;
      if (down_i)       code_o = KEY_DOWN;
      else if (left_i)  code_o = KEY_LEFT;
      else if (right_i) code_o = KEY_RIGHT;
      else if (up_i)    code_o = KEY_ROT;
   end

endmodule

// File: rtl/key_repeat_ctrl.sv
// rtl/key_repeat_ctrl.sv - held keys to one-cycle game commands with auto-repeat
module key_repeat_ctrl
   import tetris_pkg::*;
#(
   parameter int INIT_DELAY    = 25_000_000,
   parameter int REPEAT_PERIOD = 5_000_000
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       left,
   input  logic       right,
   input  logic       down,
   input  logic       up,
   input  logic       space,
   output logic [2:0] key_cmd,
   output logic       game_rst
);

   localparam int CNT_MAX = (INIT_DELAY > REPEAT_PERIOD) ? INIT_DELAY : REPEAT_PERIOD;
   localparam int CNT_W   = $clog2(CNT_MAX);
   localparam logic [CNT_W-1:0] INIT_LAST   = CNT_W'(INIT_DELAY - 1);
   localparam logic [CNT_W-1:0] REPEAT_LAST = CNT_W'(REPEAT_PERIOD - 1);

   logic             left_q, right_q, down_q, up_q, space_q, space_qq;
   kr_state_e        state_q, state_d;
   logic [2:0]       active_q, active_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic [2:0]       key_cmd_q, key_cmd_d;
   logic             game_rst_q;
   logic [2:0]       code;

   key_prio_enc u_enc (
      .down_i  (down_q),
      .left_i  (left_q),
      .right_i (right_q),
      .up_i    (up_q),
      .code_o  (code)
   );

   always_ff @(posedge clk) begin
      if (rst) begin
         left_q     <= 1'b0;
         right_q    <= 1'b0;
         down_q     <= 1'b0;
         up_q       <= 1'b0;
         space_q    <= 1'b0;
         space_qq   <= 1'b0;
         state_q    <= KR_IDLE;
         active_q   <= KEY_NONE;
         cnt_q      <= '0;
         key_cmd_q  <= KEY_NONE;
         game_rst_q <= 1'b0;
      end else begin
         left_q     <= left;
         right_q    <= right;
         down_q     <= down;
         up_q       <= up;
         space_q    <= space;
         space_qq   <= space_q;
         state_q    <= state_d;
         active_q   <= active_d;
         cnt_q      <= cnt_d;
         key_cmd_q  <= key_cmd_d;
         game_rst_q <= space_q & ~space_qq;
      end
   end

   // A new non-zero code always wins, so key changes while held restart the timers.
   always_comb begin
      state_d   = state_q;
      active_d  = active_q;
      cnt_d     = cnt_q;
      key_cmd_d = KEY_NONE;
      if (code != KEY_NONE && code != active_q) begin
         key_cmd_d = code;
         active_d  = code;
         cnt_d     = '0;
         state_d   = (code == KEY_ROT) ? KR_HOLD : KR_DELAY;
      end else if (code == KEY_NONE && state_q != KR_IDLE) begin
         state_d  = KR_IDLE;
         active_d = KEY_NONE;
         cnt_d    = '0;
      end else begin
         case (state_q)
            KR_DELAY: begin
               if (cnt_q == INIT_LAST) begin
                  key_cmd_d = active_q;
                  cnt_d     = '0;
                  state_d   = KR_REPEAT;
               end else begin
                  cnt_d = cnt_q + 1'b1;
               end
            end
            KR_REPEAT: begin
               if (cnt_q == REPEAT_LAST) begin
                  key_cmd_d = active_q;
                  cnt_d     = '0;
               end else begin
                  cnt_d = cnt_q + 1'b1;
               end
            end
            default: ;
         endcase
      end
   end

   assign key_cmd  = key_cmd_q;
   assign game_rst = game_rst_q;

endmodule

// File: tb/tb_key_repeat_ctrl.sv
// tb/tb_key_repeat_ctrl.sv - scoreboard bench for key_repeat_ctrl against a timing model
module tb_key_repeat_ctrl;

   localparam int INIT_DELAY    = 8;
   localparam int REPEAT_PERIOD = 4;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       left = 1'b0, right = 1'b0, down = 1'b0, up = 1'b0, space = 1'b0;
   logic [2:0] key_cmd;
   logic       game_rst;

   int checks   = 0;
   int failures = 0;

   always #5 clk = ~clk;

   key_repeat_ctrl #(
      .INIT_DELAY    (INIT_DELAY),
      .REPEAT_PERIOD (REPEAT_PERIOD)
   ) dut (
      .clk      (clk),
      .rst      (rst),
      .left     (left),
      .right    (right),
      .down     (down),
      .up       (up),
      .space    (space),
      .key_cmd  (key_cmd),
      .game_rst (game_rst)
   );

   // Model: keys seen one edge late; a press schedules emissions at fixed offsets from its cycle.
   logic [3:0] m_keys   = 4'b0;
   logic       m_sq     = 1'b0;
   logic       m_sqq    = 1'b0;
   logic [2:0] m_active = 3'b000;
   int         m_cyc    = 0;
   int         m_tp     = 0;
   logic [3:0] exp_q[$];

   function automatic logic [2:0] enc(input logic [3:0] k);
      if (k[3]) return 3'b100;
      if (k[2]) return 3'b101;
      if (k[1]) return 3'b110;
      if (k[0]) return 3'b111;
      return 3'b000;
   endfunction

   always @(posedge clk) begin : model
      logic [2:0] c;
      logic [2:0] e;
      int         el;
      m_cyc = m_cyc + 1;
      if (rst) begin
         exp_q.push_back(4'b0000);
         m_keys   = 4'b0;
         m_sq     = 1'b0;
         m_sqq    = 1'b0;
         m_active = 3'b000;
      end else begin
         c = enc(m_keys);
         e = 3'b000;
         if (c != 3'b000 && c != m_active) begin
            e        = c;
            m_active = c;
            m_tp     = m_cyc;
         end else if (c == 3'b000) begin
            m_active = 3'b000;
         end else if (m_active != 3'b111) begin
            el = m_cyc - m_tp;
            if (el == INIT_DELAY || (el > INIT_DELAY && (el - INIT_DELAY) % REPEAT_PERIOD == 0))
               e = m_active;
         end
         exp_q.push_back({e, m_sq & ~m_sqq});
         m_sqq  = m_sq;
         m_sq   = space;
         m_keys = {down, left, right, up};
      end
   end

   always @(negedge clk) begin : monitor
      logic [3:0] ex;
      if (exp_q.size() > 0) begin
         ex = exp_q.pop_front();
         checks = checks + 1;
         if ({key_cmd, game_rst} !== ex) begin
            failures = failures + 1;
            $display("FAIL out t=%0t key_cmd=%b game_rst=%b expected key_cmd=%b game_rst=%b",
                     $time, key_cmd, game_rst, ex[3:1], ex[0]);
         end
      end
   end

   task automatic idle(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic set_keys(input logic [4:0] v);
      {down, left, right, up, space} = v;
   endtask

   initial begin
      idle(2);
      rst = 1'b0;
      idle(3);
      left = 1'b1; idle(3); left = 1'b0; idle(12);
      right = 1'b1; idle(30); right = 1'b0; idle(12);
      up = 1'b1; idle(30); up = 1'b0; idle(3);
      up = 1'b1; idle(30); up = 1'b0; idle(10);
      left = 1'b1; idle(10); down = 1'b1; idle(15);
      down = 1'b0; idle(15); left = 1'b0; idle(10);
      space = 1'b1; idle(20); space = 1'b0; idle(5);
      right = 1'b1; idle(12); space = 1'b1; idle(3); space = 1'b0; idle(10);
      right = 1'b0; idle(5);
      down = 1'b1; idle(7); rst = 1'b1; idle(2); rst = 1'b0; idle(20);
      down = 1'b0; idle(5);
      repeat (300) begin
         set_keys(5'($urandom_range(0, 31)));
         if ($urandom_range(0, 19) == 0) rst = 1'b1;
         idle(1);
         rst = 1'b0;
         idle($urandom_range(0, 20));
      end
      set_keys(5'b0);
      idle(15);
      checks = checks + 1;
      if (exp_q.size() > 1) begin
         failures = failures + 1;
         $display("FAIL drain pending=%0d expected<=1", exp_q.size());
      end
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
